// File: rtl/io_request_queue.sv
// io_request_queue: in-order I/O request FIFO feeding a single-outstanding bus sequencer.
// Define IO_QUEUE_STATS_EN to add load/store strobe counters and a FIFO high-water mark.
package io_request_queue_pkg;
  typedef logic [3:0] core_id_t;
  typedef struct packed {
    logic        store;
    logic [3:0]  thread_idx;
    logic [31:0] address;
    logic [31:0] value;
  } ioreq_packet_t;
  typedef struct packed {
    core_id_t    core;
    logic [3:0]  thread_idx;
    logic [31:0] read_value;
  } iorsp_packet_t;
endpackage

module io_request_queue
  import io_request_queue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  core_id_t      core_id,
  input  logic          ioreq_valid,
  input  ioreq_packet_t ioreq,
  output logic          ioreq_ready,
  output logic          iorsp_valid,
  output iorsp_packet_t iorsp,
  input  logic          iorsp_ready,
  output logic          io_bus_write_en,
  output logic          io_bus_read_en,
  output logic [31:0]   io_bus_address,
  output logic [31:0]   io_bus_write_data,
  input  logic [31:0]   io_bus_read_data
`ifdef IO_QUEUE_STATS_EN
  ,
  output logic [31:0]   load_count,
  output logic [31:0]   store_count,
  output logic [AW:0]   max_occupancy
`endif
);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, READ_WAIT, RESPOND} state_t;
  state_t        state;
  ioreq_packet_t mem [FIFO_DEPTH];
  ioreq_packet_t head;
  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic          push, pop;
  assign count       = wr_ptr - rd_ptr;
  assign ioreq_ready = count != FULL;
  assign head        = mem[rd_ptr[AW-1:0]];
  assign push        = ioreq_valid && ioreq_ready;
  assign pop         = state == RESPOND && iorsp_ready;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ioreq;
  end
  // The head entry stays in the FIFO until its response transfers, so it is the context for the whole access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      iorsp_valid       <= 1'b0;
      iorsp             <= '0;
      io_bus_write_en   <= 1'b0;
      io_bus_read_en    <= 1'b0;
      io_bus_address    <= '0;
      io_bus_write_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      case (state)
        IDLE: if (count != '0) begin
          state             <= ISSUE;
          io_bus_write_en   <= head.store;
          io_bus_read_en    <= !head.store;
          io_bus_address    <= head.address;
          io_bus_write_data <= head.value;
        end
        ISSUE: begin
          io_bus_write_en <= 1'b0;
          io_bus_read_en  <= 1'b0;
          state           <= head.store ? RESPOND : READ_WAIT;
          if (head.store) begin
            iorsp_valid <= 1'b1;
            iorsp       <= '{core: core_id, thread_idx: head.thread_idx, read_value: 32'h0};
          end
        end
        READ_WAIT: begin
          state       <= RESPOND;
          iorsp_valid <= 1'b1;
          iorsp       <= '{core: core_id, thread_idx: head.thread_idx, read_value: io_bus_read_data};
        end
        RESPOND: if (iorsp_ready) begin
          iorsp_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef IO_QUEUE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_count    <= '0;
      store_count   <= '0;
      max_occupancy <= '0;
    end else begin
      if (state == IDLE && count != '0) begin
        store_count <= store_count + 32'(head.store);
        load_count  <= load_count + 32'(!head.store);
      end
      if (count > max_occupancy) max_occupancy <= count;
    end
  end
`endif
endmodule

// File: tb/tb_io_request_queue.sv
// tb_io_request_queue: directed checks of io_request_queue latency, ordering, backpressure and reset.
module tb_io_request_queue;
  import io_request_queue_pkg::*;
  localparam logic [31:0] KEY = 32'hEDCB567C;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  core_id_t      core_id = 4'd3;
  logic          ioreq_valid = 1'b0;
  ioreq_packet_t ioreq = '0;
  logic          ioreq_ready;
  logic          iorsp_valid;
  iorsp_packet_t iorsp;
  logic          iorsp_ready = 1'b0;
  logic          io_bus_write_en, io_bus_read_en;
  logic [31:0]   io_bus_address, io_bus_write_data;
  logic [31:0]   io_bus_read_data = 32'h0;
`ifdef IO_QUEUE_STATS_EN
  logic [31:0]   load_count, store_count;
  logic [2:0]    max_occupancy;
`endif
  int checks = 0;
  int fails = 0;

  io_request_queue #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .core_id(core_id),
    .ioreq_valid(ioreq_valid), .ioreq(ioreq), .ioreq_ready(ioreq_ready),
    .iorsp_valid(iorsp_valid), .iorsp(iorsp), .iorsp_ready(iorsp_ready),
    .io_bus_write_en(io_bus_write_en), .io_bus_read_en(io_bus_read_en),
    .io_bus_address(io_bus_address), .io_bus_write_data(io_bus_write_data),
    .io_bus_read_data(io_bus_read_data)
`ifdef IO_QUEUE_STATS_EN
    , .load_count(load_count), .store_count(store_count), .max_occupancy(max_occupancy)
`endif
  );

  always #5 clk = ~clk;

  // Bus slave: read data is valid only in the cycle after the read strobe.
  always @(posedge clk) io_bus_read_data <= io_bus_read_en ? (io_bus_address ^ KEY) : 32'h0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (ioreq_ready !== 1'b1) begin fails++; $display("FAIL reset_ioreq_ready: got %b want 1", ioreq_ready); end
    checks++; if ({io_bus_write_en, io_bus_read_en, iorsp_valid} !== 3'b000) begin fails++; $display("FAIL reset_strobes: got %b want 000", {io_bus_write_en, io_bus_read_en, iorsp_valid}); end
    checks++; if (iorsp !== '0) begin fails++; $display("FAIL reset_iorsp: got %h want 0", iorsp); end
    checks++; if ({io_bus_address, io_bus_write_data} !== 64'h0) begin fails++; $display("FAIL reset_bus: got %h want 0", {io_bus_address, io_bus_write_data}); end
    step;
    reset_n = 1'b1;
    step;
  endtask

  task automatic test_load;
    iorsp_packet_t exp;
    exp = '{core: 4'd3, thread_idx: 4'd2, read_value: 32'h12345678};
    ioreq = '{store: 1'b0, thread_idx: 4'd2, address: 32'hFFFF0004, value: 32'h0};
    ioreq_valid = 1'b1;
    iorsp_ready = 1'b0;
    step;
    ioreq_valid = 1'b0;
    checks++; if ({io_bus_write_en, io_bus_read_en} !== 2'b00) begin fails++; $display("FAIL load_t1_strobe: got %b want 00", {io_bus_write_en, io_bus_read_en}); end
    step;
    checks++; if ({io_bus_write_en, io_bus_read_en} !== 2'b01) begin fails++; $display("FAIL load_t2_strobe: got %b want 01", {io_bus_write_en, io_bus_read_en}); end
    checks++; if (io_bus_address !== 32'hFFFF0004) begin fails++; $display("FAIL load_address: got %h want FFFF0004", io_bus_address); end
    step;
    checks++; if ({io_bus_write_en, io_bus_read_en, iorsp_valid} !== 3'b000) begin fails++; $display("FAIL load_t3: got %b want 000", {io_bus_write_en, io_bus_read_en, iorsp_valid}); end
    step;
    checks++; if (iorsp_valid !== 1'b1) begin fails++; $display("FAIL load_t4_valid: got %b want 1", iorsp_valid); end
    checks++; if (iorsp !== exp) begin fails++; $display("FAIL load_iorsp: got %h want %h", iorsp, exp); end
    step;
    checks++; if (iorsp_valid !== 1'b1 || iorsp !== exp) begin fails++; $display("FAIL load_hold: got %b/%h want 1/%h", iorsp_valid, iorsp, exp); end
    iorsp_ready = 1'b1;
    step;
    iorsp_ready = 1'b0;
    checks++; if (iorsp_valid !== 1'b0) begin fails++; $display("FAIL load_pop: got %b want 0", iorsp_valid); end
  endtask

  task automatic test_store;
    iorsp_packet_t exp;
    exp = '{core: 4'd3, thread_idx: 4'd1, read_value: 32'h0};
    ioreq = '{store: 1'b1, thread_idx: 4'd1, address: 32'hFFFF0000, value: 32'hA5};
    ioreq_valid = 1'b1;
    step;
    ioreq_valid = 1'b0;
    step;
    checks++; if ({io_bus_write_en, io_bus_read_en} !== 2'b10) begin fails++; $display("FAIL store_strobe: got %b want 10", {io_bus_write_en, io_bus_read_en}); end
    checks++; if ({io_bus_address, io_bus_write_data} !== {32'hFFFF0000, 32'hA5}) begin fails++; $display("FAIL store_bus: got %h/%h want FFFF0000/A5", io_bus_address, io_bus_write_data); end
    checks++; if (iorsp_valid !== 1'b0) begin fails++; $display("FAIL store_t2_valid: got %b want 0", iorsp_valid); end
    step;
    checks++; if ({io_bus_write_en, io_bus_read_en} !== 2'b00) begin fails++; $display("FAIL store_t3_strobe: got %b want 00", {io_bus_write_en, io_bus_read_en}); end
    checks++; if (iorsp_valid !== 1'b1 || iorsp !== exp) begin fails++; $display("FAIL store_iorsp: got %b/%h want 1/%h", iorsp_valid, iorsp, exp); end
    iorsp_ready = 1'b1;
    step;
    iorsp_ready = 1'b0;
    checks++; if (iorsp_valid !== 1'b0) begin fails++; $display("FAIL store_pop: got %b want 0", iorsp_valid); end
  endtask

  task automatic test_full;
    int got = 0;
    logic acc;
    iorsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ioreq = '{store: 1'b0, thread_idx: 4'(i), address: 32'hFFFF0100 + 32'(4 * i), value: 32'h0};
      ioreq_valid = 1'b1;
      checks++; if (ioreq_ready !== 1'b1) begin fails++; $display("FAIL full_accept%0d: got %b want 1", i, ioreq_ready); end
      step;
    end
    ioreq = '{store: 1'b0, thread_idx: 4'd4, address: 32'hFFFF0110, value: 32'h0};
    checks++; if (ioreq_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", ioreq_ready); end
    repeat (5) step;
    checks++; if (ioreq_ready !== 1'b0) begin fails++; $display("FAIL full_stall_ready: got %b want 0", ioreq_ready); end
    iorsp_ready = 1'b1;
    for (int c = 0; c < 100 && got < 5; c++) begin
      acc = ioreq_valid && ioreq_ready;
      if (acc) begin
        checks++; if (got == 0) begin fails++; $display("FAIL full_early_accept: got %0d responses want >=1", got); end
      end
      if (iorsp_valid) begin
        checks++; if (iorsp.thread_idx !== 4'(got)) begin fails++; $display("FAIL full_order: got %0d want %0d", iorsp.thread_idx, got); end
        checks++; if (iorsp.read_value !== ((32'hFFFF0100 + 32'(4 * got)) ^ KEY)) begin fails++; $display("FAIL full_data%0d: got %h want %h", got, iorsp.read_value, (32'hFFFF0100 + 32'(4 * got)) ^ KEY); end
        got++;
      end
      step;
      if (acc) ioreq_valid = 1'b0;
    end
    checks++; if (got !== 5) begin fails++; $display("FAIL full_count: got %0d want 5", got); end
    checks++; if (ioreq_valid !== 1'b0) begin fails++; $display("FAIL full_fifth_accepted: got %b want 0", ioreq_valid); end
    ioreq_valid = 1'b0;
    iorsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic st [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int pi = 0, ns = 0, nr = 0, last = 0;
    logic acc;
    logic [31:0] a;
    iorsp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      ioreq_valid = pi < 4;
      if (pi < 4) ioreq = '{store: st[pi], thread_idx: 4'(8 + pi), address: 32'hFFFF0200 + 32'(4 * pi), value: 32'(pi + 16)};
      acc = ioreq_valid && ioreq_ready;
      if (io_bus_write_en || io_bus_read_en) begin
        checks++; if (io_bus_write_en && io_bus_read_en) begin fails++; $display("FAIL b2b_both: got 11 want exclusive"); end
        if (ns < 4) begin
          checks++; if (io_bus_write_en !== st[ns]) begin fails++; $display("FAIL b2b_kind%0d: got %b want %b", ns, io_bus_write_en, st[ns]); end
          checks++; if (c !== (ns == 0 ? 2 : last + (st[ns-1] ? 3 : 4))) begin fails++; $display("FAIL b2b_cycle%0d: got %0d want %0d", ns, c, ns == 0 ? 2 : last + (st[ns-1] ? 3 : 4)); end
        end
        last = c;
        ns++;
      end
      if (iorsp_valid) begin
        a = 32'hFFFF0200 + 32'(4 * nr);
        checks++; if (iorsp.thread_idx !== 4'(8 + nr)) begin fails++; $display("FAIL b2b_order: got %0d want %0d", iorsp.thread_idx, 8 + nr); end
        if (nr < 4) begin
          checks++; if (iorsp.read_value !== (st[nr] ? 32'h0 : a ^ KEY)) begin fails++; $display("FAIL b2b_data%0d: got %h want %h", nr, iorsp.read_value, st[nr] ? 32'h0 : a ^ KEY); end
        end
        nr++;
      end
      step;
      if (acc) pi++;
    end
    ioreq_valid = 1'b0;
    checks++; if (ns !== 4) begin fails++; $display("FAIL b2b_strobes: got %0d want 4", ns); end
    checks++; if (nr !== 4) begin fails++; $display("FAIL b2b_responses: got %0d want 4", nr); end
  endtask

  task automatic test_reset_mid;
    int extra = 0;
    iorsp_ready = 1'b1;
    ioreq = '{store: 1'b0, thread_idx: 4'd5, address: 32'hFFFF0300, value: 32'h0};
    ioreq_valid = 1'b1;
    step;
    ioreq_valid = 1'b0;
    step;
    step;
    checks++; if ({io_bus_read_en, iorsp_valid} !== 2'b00) begin fails++; $display("FAIL mid_read_wait: got %b want 00", {io_bus_read_en, iorsp_valid}); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if ({io_bus_write_en, io_bus_read_en, iorsp_valid} !== 3'b000) begin fails++; $display("FAIL mid_reset_strobes: got %b want 000", {io_bus_write_en, io_bus_read_en, iorsp_valid}); end
    checks++; if (iorsp !== '0 || io_bus_address !== 32'h0) begin fails++; $display("FAIL mid_reset_regs: got %h/%h want 0/0", iorsp, io_bus_address); end
    @(negedge clk);
    reset_n = 1'b1;
    checks++; if (ioreq_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: got %b want 1", ioreq_ready); end
    repeat (10) begin
      step;
      if (iorsp_valid || io_bus_read_en || io_bus_write_en) extra++;
    end
    checks++; if (extra !== 0) begin fails++; $display("FAIL mid_dropped: got %0d active cycles want 0", extra); end
    iorsp_ready = 1'b0;
  endtask

`ifdef IO_QUEUE_STATS_EN
  task automatic test_stats;
    logic st [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int got = 0;
    logic acc;
    iorsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ioreq = '{store: st[i], thread_idx: 4'(i), address: 32'hFFFF0400 + 32'(4 * i), value: 32'(i)};
      ioreq_valid = 1'b1;
      step;
    end
    ioreq = '{store: st[4], thread_idx: 4'd4, address: 32'hFFFF0410, value: 32'd4};
    repeat (4) step;
    checks++; if (max_occupancy !== 3'd4) begin fails++; $display("FAIL stats_max_stalled: got %0d want 4", max_occupancy); end
    iorsp_ready = 1'b1;
    for (int c = 0; c < 100 && got < 5; c++) begin
      acc = ioreq_valid && ioreq_ready;
      if (iorsp_valid) got++;
      step;
      if (acc) ioreq_valid = 1'b0;
    end
    step;
    checks++; if (got !== 5) begin fails++; $display("FAIL stats_drain: got %0d want 5", got); end
    checks++; if (load_count !== 32'd3) begin fails++; $display("FAIL stats_load_count: got %0d want 3", load_count); end
    checks++; if (store_count !== 32'd2) begin fails++; $display("FAIL stats_store_count: got %0d want 2", store_count); end
    checks++; if (max_occupancy !== 3'd4) begin fails++; $display("FAIL stats_max: got %0d want 4", max_occupancy); end
    ioreq_valid = 1'b0;
    iorsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_load;
    test_store;
    test_full;
    test_back_to_back;
    test_reset_mid;
`ifdef IO_QUEUE_STATS_EN
    test_stats;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
